// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// Opcodes, functs, state codes and datapath select values.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_JR        = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REGA   = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

endpackage

// File: rtl/mips_ctrl_dispatch.sv
// DECODE-state dispatch: maps opcode/funct to the first execute state.
// Anything not recognised lands in TRAP.
module mips_ctrl_dispatch
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output state_t     o_next
);

    // Pure lookup; unsupported encodings fall through to TRAP
    always_comb begin
        o_next = S_TRAP;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD, FN_ADDU, FN_SLT: o_next = S_R_EXEC;
                    FN_JR:                   o_next = S_JR;
                    default:                 o_next = S_TRAP;
                endcase
            end
            OP_LW, OP_SW:      o_next = S_MEM_ADDR;
            OP_ADDI, OP_ADDIU: o_next = S_I_EXEC;
            OP_BEQ, OP_BNE:    o_next = S_BRANCH;
            OP_JAL:            o_next = S_JAL;
            default:           o_next = S_TRAP;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM over a shared variable-latency memory.
// Optional MC_PERF_COUNTERS_EN adds cycle_cnt / instr_cnt outputs.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               iord,
    output logic               ir_wr,
    output logic               pc_wr,
    output logic               pc_wr_cond,
    output logic [1:0]         pc_src,
    output logic               reg_wr,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [STATE_W-1:0] state,
    output logic               illegal
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instr_cnt
`endif
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_dispatch;
    logic       r_illegal;
    logic       w_mem_rd;
    logic       w_mem_wr;
    logic       w_ir_wr;
    logic       w_pc_wr;
    logic       w_pc_wr_cond;
    logic       w_reg_wr;
    logic [2:0] w_alu_op;

    mips_ctrl_dispatch u_dispatch (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_next   (w_dispatch)
    );

    // State register and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_TRAP)
                r_illegal <= 1'b1;
        end
    end

    // Per-state datapath controls and next state (Mealy on mem_ready)
    always_comb begin
        w_next       = r_state;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_ir_wr      = 1'b0;
        w_pc_wr      = 1'b0;
        w_pc_wr_cond = 1'b0;
        w_reg_wr     = 1'b0;
        w_alu_op     = ALU_ADD;
        iord         = 1'b0;
        pc_src       = PC_ALU;
        reg_dst      = RD_RT;
        mem_to_reg   = M2R_ALUOUT;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_B;
        case (r_state)
            S_FETCH: begin
                w_mem_rd  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    w_ir_wr = 1'b1;
                    w_pc_wr = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                w_next    = w_dispatch;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = (opcode == OP_SW) ? S_MEM_WRITE
                                              : S_MEM_READ;
            end
            S_MEM_READ: begin
                w_mem_rd = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_reg_wr   = 1'b1;
                mem_to_reg = M2R_MDR;
                w_next     = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_mem_wr = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    w_next = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                w_alu_op  = (funct == FN_SLT) ? ALU_SLT : ALU_ADD;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                w_reg_wr = 1'b1;
                reg_dst  = RD_RD;
                w_next   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = S_I_WB;
            end
            S_I_WB: begin
                w_reg_wr = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                w_alu_op     = ALU_SUB;
                pc_src       = PC_ALUOUT;
                w_pc_wr_cond = (opcode == OP_BNE) ? ~alu_zero
                                                  : alu_zero;
                w_next       = S_FETCH;
            end
            S_JAL: begin
                w_reg_wr   = 1'b1;
                reg_dst    = RD_RA;
                mem_to_reg = M2R_PC;
                w_pc_wr    = 1'b1;
                pc_src     = PC_JUMP;
                w_next     = S_FETCH;
            end
            S_JR: begin
                w_pc_wr = 1'b1;
                pc_src  = PC_REGA;
                w_next  = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Strobes are masked by reset so an access dies without a clock edge
    assign mem_rd     = w_mem_rd & rst_n;
    assign mem_wr     = w_mem_wr & rst_n;
    assign ir_wr      = w_ir_wr & rst_n;
    assign pc_wr      = w_pc_wr & rst_n;
    assign pc_wr_cond = w_pc_wr_cond & rst_n;
    assign reg_wr     = w_reg_wr & rst_n;
    assign alu_op     = ALUOP_W'(w_alu_op);
    assign state      = STATE_W'(r_state);
    assign illegal    = r_illegal;

`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    // Free-running cycle count (frozen in TRAP) and retired-instruction count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= 32'd0;
            r_instr_cnt <= 32'd0;
        end else begin
            if (r_state != S_TRAP)
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (r_state != S_FETCH && w_next == S_FETCH)
                r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

endmodule
